trigger_unit: RTL

- Parametrised successor to the fixed sample-count trigger: a threshold/edge trigger on a streaming sample bus, with pre-trigger and post-trigger sample counts.
- Sits between the ADC sample stream and the capture buffer. Drives the buffer write enable (capture_en), the trigger position and completion.
- Config is latched at arm; runs one acquisition per arm.

---
 rtl/trigger_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/trigger_unit.sv
// Threshold/edge trigger on a signed sample stream, with pre- and post-trigger sample counts.
// Optional macro AUTO_TRIG_EN forces a trigger after AUTO_TIMEOUT armed samples and adds trig_auto.
module trigger_unit #(
  parameter int DATA_W       = 12,
  parameter int CNT_W        = 16,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] threshold,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  pre_count,
  input  logic [CNT_W-1:0]  post_count,
  output logic              busy,
  output logic              capture_en,
  output logic              trigger,
  output logic [CNT_W-1:0]  trig_pos,
  output logic              done
`ifdef AUTO_TRIG_EN
  ,
  output logic              trig_auto
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ARMED, S_POST} state_e;
  typedef enum logic [1:0] {M_RISE, M_FALL, M_EITHER, M_LEVEL} mode_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (AUTO_TIMEOUT < 1) begin : g_bad_timeout
    $error("AUTO_TIMEOUT must be at least 1");
  end

  state_e                    state;
  mode_e                     mode_q;
  logic signed [DATA_W-1:0]  thr_q;
  logic signed [DATA_W-1:0]  prev_q;
  logic signed [DATA_W-1:0]  cur;
  logic                      prev_ok;
  logic [CNT_W-1:0]          pre_q;
  logic [CNT_W-1:0]          post_q;
  logic [CNT_W-1:0]          idx_q;
  logic [CNT_W-1:0]          idx_inc;
  logic [CNT_W-1:0]          post_cnt;
  logic                      active_q;
  logic                      cur_ge;
  logic                      prev_ge;
  logic                      hit;
  logic                      pre_end;
  logic                      post_last;
  logic                      force_trig;

`ifdef AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  assign busy       = active_q;
  assign capture_en = active_q;
  assign cur        = sample_data;

  always_comb begin
    cur_ge    = cur >= thr_q;
    prev_ge   = prev_q >= thr_q;
    hit       = 1'b0;
    unique case (mode_q)
      M_RISE:   hit = prev_ok && !prev_ge && cur_ge;
      M_FALL:   hit = prev_ok && prev_ge && !cur_ge;
      M_EITHER: hit = prev_ok && (prev_ge != cur_ge);
      M_LEVEL:  hit = cur_ge;
      default:  hit = 1'b0;
    endcase
    idx_inc   = (&idx_q) ? idx_q : idx_q + CNT_ONE;
    pre_end   = (pre_q == '0) || (sample_valid && (idx_q == pre_q - CNT_ONE));
    post_last = (post_cnt + CNT_ONE) == post_q;
`ifdef AUTO_TRIG_EN
    force_trig = to_cnt == TO_W'(AUTO_TIMEOUT - 1);
`else
    force_trig = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mode_q   <= M_RISE;
      thr_q    <= '0;
      prev_q   <= '0;
      prev_ok  <= 1'b0;
      pre_q    <= '0;
      post_q   <= '0;
      idx_q    <= '0;
      post_cnt <= '0;
      active_q <= 1'b0;
      trigger  <= 1'b0;
      done     <= 1'b0;
      trig_pos <= '0;
`ifdef AUTO_TRIG_EN
      to_cnt    <= '0;
      trig_auto <= 1'b0;
`endif
    end else begin
      trigger <= 1'b0;
      done    <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        active_q <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (arm) begin
              thr_q    <= threshold;
              mode_q   <= mode_e'(mode);
              pre_q    <= pre_count;
              post_q   <= post_count;
              idx_q    <= '0;
              prev_ok  <= 1'b0;
              active_q <= 1'b1;
              state    <= S_PRE;
`ifdef AUTO_TRIG_EN
              to_cnt    <= '0;
              trig_auto <= 1'b0;
`endif
            end
          end
          S_PRE: begin
            // prev keeps tracking here so the first armed sample can already edge-trigger
            if (sample_valid) begin
              prev_q  <= cur;
              prev_ok <= 1'b1;
              idx_q   <= idx_inc;
            end
            if (pre_end) state <= S_ARMED;
          end
          S_ARMED: begin
            if (sample_valid) begin
              prev_q  <= cur;
              prev_ok <= 1'b1;
              idx_q   <= idx_inc;
`ifdef AUTO_TRIG_EN
              to_cnt  <= to_cnt + TO_W'(1);
`endif
              if (hit || force_trig) begin
                trigger  <= 1'b1;
                trig_pos <= idx_q;
                post_cnt <= '0;
                state    <= S_POST;
`ifdef AUTO_TRIG_EN
                trig_auto <= !hit;
`endif
              end
            end
          end
          S_POST: begin
            if (post_q == '0) begin
              done     <= 1'b1;
              active_q <= 1'b0;
              state    <= S_IDLE;
            end else if (sample_valid) begin
              if (post_last) begin
                done     <= 1'b1;
                active_q <= 1'b0;
                state    <= S_IDLE;
              end else begin
                post_cnt <= post_cnt + CNT_ONE;
              end
            end
          end
          default: begin
            state    <= S_IDLE;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
